// File: rtl/edn_ep_arbiter_if.sv
// edn_ep_arbiter_if: endpoint request/ack/data bus plus genbits FIFO read port; master = arbiter side, slave = endpoints/FIFO side
interface edn_ep_arbiter_if #(
  parameter int NumEndPoints = 7,
  parameter int BusWidth = 32
);
  logic [NumEndPoints-1:0] ep_req;
  logic [NumEndPoints-1:0] ep_ack;
  logic [BusWidth-1:0] ep_bus;
  logic ep_fips;
  logic fifo_rvalid;
  logic [BusWidth-1:0] fifo_rdata;
  logic fifo_fips;
  logic fifo_rready;
  modport master (
    input ep_req, fifo_rvalid, fifo_rdata, fifo_fips,
    output ep_ack, ep_bus, ep_fips, fifo_rready
  );
  modport slave (
    output ep_req, fifo_rvalid, fifo_rdata, fifo_fips,
    input ep_ack, ep_bus, ep_fips, fifo_rready
  );
endinterface

// File: rtl/edn_ep_arbiter.sv
// edn_ep_arbiter: round-robin share of the genbits FIFO; ports clk_i/rst_i (sync high), enable_i, ep (if master), words_o (saturating count), last_grant_o
module edn_ep_arbiter #(
  parameter int NumEndPoints = 7,
  parameter int BusWidth = 32,
  parameter int CntWidth = 16,
  parameter int IdxW = $clog2(NumEndPoints)
) (
  input logic clk_i,
  input logic rst_i,
  input logic enable_i,
  edn_ep_arbiter_if.master ep,
  output logic [CntWidth-1:0] words_o,
  output logic [IdxW-1:0] last_grant_o
);
  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] winner;
  logic grant;
  assign grant = enable_i & |ep.ep_req & ep.fifo_rvalid & ~rst_i;
  assign ep.fifo_rready = grant;
  always_comb begin
    winner = ptr;
    for (int k = NumEndPoints; k >= 1; k--)
      if (ep.ep_req[IdxW'((int'(ptr) + k) % NumEndPoints)]) winner = IdxW'((int'(ptr) + k) % NumEndPoints);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ep.ep_ack <= '0;
      ep.ep_bus <= {BusWidth{1'b0}};
      ep.ep_fips <= 1'b0;
      words_o <= '0;
      last_grant_o <= '0;
      ptr <= IdxW'(NumEndPoints - 1);
    end else begin
      ep.ep_ack <= grant ? NumEndPoints'(1) << winner : '0;
      ep.ep_bus <= grant ? ep.fifo_rdata : enable_i ? ep.ep_bus : {BusWidth{1'b0}};
      ep.ep_fips <= grant ? ep.fifo_fips : enable_i & ep.ep_fips;
      words_o <= words_o + CntWidth'(grant && words_o != '1);
      if (grant) begin
        ptr <= winner;
        last_grant_o <= winner;
      end
    end
  end
endmodule

// File: tb/tb_edn_ep_arbiter.sv
// tb_edn_ep_arbiter: scoreboard bench for edn_ep_arbiter with a 4-bit word counter
module tb_edn_ep_arbiter;
  localparam int N = 7;
  localparam int BW = 32;
  localparam int CW = 4;
  localparam int CMAX = 2 ** CW - 1;
  logic clk = 0;
  logic rst = 1;
  logic en = 1;
  logic [CW-1:0] words;
  logic [2:0] last;
  edn_ep_arbiter_if #(.NumEndPoints(N), .BusWidth(BW)) ifc ();
  edn_ep_arbiter #(.NumEndPoints(N), .BusWidth(BW), .CntWidth(CW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .enable_i(en),
    .ep(ifc),
    .words_o(words),
    .last_grant_o(last)
  );
  always #5 clk = ~clk;
  typedef struct {
    int idx;
    logic [BW-1:0] data;
    logic fips;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int seq = 1;
  int m_ptr = N - 1;
  int m_last = 0;
  int m_words = 0;
  logic [BW-1:0] m_bus = '0;
  logic m_fips = 1'b0;
  bit popped = 0;
  bit run = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask
  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int k = 1; k <= N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return p;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    bit g;
    if (run) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ack", ifc.ep_ack, N'(1) << e.idx);
        chk("ack_data", ifc.ep_bus, e.data);
        chk("ack_fips", ifc.ep_fips, e.fips);
      end else chk("ack_idle", ifc.ep_ack, 0);
      chk("bus", ifc.ep_bus, m_bus);
      chk("fips", ifc.ep_fips, m_fips);
      chk("words", words, m_words);
      chk("last", last, m_last);
      g = en & (|ifc.ep_req) & ifc.fifo_rvalid & ~rst;
      chk("rready", ifc.fifo_rready, g);
      popped = g;
      if (rst) begin
        q.delete();
        m_ptr = N - 1;
        m_last = 0;
        m_words = 0;
        m_bus = '0;
        m_fips = 0;
      end else if (g) begin
        m_ptr = pick(ifc.ep_req, m_ptr);
        m_last = m_ptr;
        m_words = m_words == CMAX ? CMAX : m_words + 1;
        m_bus = ifc.fifo_rdata;
        m_fips = ifc.fifo_fips;
        q.push_back('{m_ptr, m_bus, m_fips});
      end else if (!en) begin
        m_bus = '0;
        m_fips = 0;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    if (popped) begin
      seq++;
      ifc.fifo_rdata = 32'hA5A5_0000 + seq;
      ifc.fifo_fips = seq[0];
    end
  endtask
  task automatic reset_dut();
    rst = 1;
    step();
    rst = 0;
  endtask
  initial begin
    ifc.ep_req = '0;
    ifc.fifo_rvalid = 1;
    ifc.fifo_rdata = 32'hA5A5_0001;
    ifc.fifo_fips = 1;
    run = 1;
    repeat (2) step();
    rst = 0;
    repeat (2) step();
    chk("rst_ack", ifc.ep_ack, 0);
    chk("rst_bus", ifc.ep_bus, 0);
    chk("rst_words", words, 0);
    chk("rst_last", last, 0);
    chk("rst_rready", ifc.fifo_rready, 0);
    ifc.ep_req = 7'b0000100;
    step();
    ifc.ep_req = '0;
    chk("single_ack", ifc.ep_ack, 7'b0000100);
    chk("single_bus", ifc.ep_bus, 32'hA5A5_0001);
    chk("single_fips", ifc.ep_fips, 1);
    chk("single_words", words, 1);
    chk("single_last", last, 2);
    reset_dut();
    ifc.ep_req = '1;
    repeat (14) step();
    ifc.ep_req = '0;
    chk("rr_words", words, 14);
    chk("rr_last", last, 6);
    reset_dut();
    ifc.fifo_rvalid = 0;
    ifc.ep_req = 7'b0100010;
    repeat (10) step();
    chk("stall_ack", ifc.ep_ack, 0);
    chk("stall_last", last, 0);
    ifc.fifo_rvalid = 1;
    step();
    chk("stall_ep1", ifc.ep_ack, 7'b0000010);
    step();
    ifc.ep_req = '0;
    chk("stall_ep5", ifc.ep_ack, 7'b0100000);
    reset_dut();
    ifc.ep_req = '1;
    repeat (3) step();
    chk("dis_done", ifc.ep_ack, 7'b0000100);
    en = 0;
    step();
    chk("dis_ack", ifc.ep_ack, 0);
    chk("dis_bus", ifc.ep_bus, 0);
    chk("dis_fips", ifc.ep_fips, 0);
    repeat (2) step();
    en = 1;
    step();
    chk("dis_resume", ifc.ep_ack, 7'b0001000);
    reset_dut();
    repeat (20) step();
    chk("sat_words", words, CMAX);
    rst = 1;
    step();
    chk("mid_rst_ack", ifc.ep_ack, 0);
    chk("mid_rst_bus", ifc.ep_bus, 0);
    chk("mid_rst_words", words, 0);
    chk("mid_rst_last", last, 0);
    rst = 0;
    step();
    ifc.ep_req = '0;
    chk("post_rst_ack", ifc.ep_ack, 7'b0000001);
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
